// File: rtl/trace_pkg.sv
// Shared types for the pc trace recorder: entry layout, serializer states, boot pc.
package trace_pkg;
  localparam logic [31:0] TRACE_RESET_PC = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_PC   = 2'd1,
    ST_SEND_INST = 2'd2
  } ser_state_t;
endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head entry is visible on rd_data without a read.
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign count   = r_wr_ptr - r_rd_ptr;
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/pc_trace_buffer.sv
// Captures {pc, inst} on every pc change into a FIFO and drains it as a
// pc-word / inst-word valid/ready stream, counting events lost to a full FIFO.
module pc_trace_buffer
  import trace_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = TRACE_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic                   clk_in,
  input  logic                   reset_n,
  input  logic                   trace_en,
  input  logic [31:0]            pc,
  input  logic [31:0]            inst,
  input  logic                   clr_ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic                   out_last,
  output logic                   ovf_flag,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [$clog2(DEPTH):0] level
);
  logic [31:0]  r_prev_pc;
  logic         r_ovf;
  logic [CNT_W-1:0] r_drop_cnt;
  trace_entry_t r_hold;
  ser_state_t   r_state;
  ser_state_t   w_state_nxt;

  logic         w_chg;
  logic         w_evt;
  logic         w_push;
  logic         w_drop;
  logic         w_load;
  logic         w_full;
  logic         w_empty;
  trace_entry_t w_wr_entry;
  trace_entry_t w_head;

  assign w_chg      = (pc != r_prev_pc);
  assign w_evt      = trace_en && w_chg;
  // full is the start-of-cycle occupancy, so a same-cycle pop never rescues the event
  assign w_push     = w_evt && !w_full;
  assign w_drop     = w_evt && w_full;
  assign w_wr_entry = '{pc: pc, inst: inst};

  trace_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .wr_en   (w_push),
    .wr_data (w_wr_entry),
    .rd_en   (w_load),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (level)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) r_prev_pc <= RESET_PC;
    else if (w_chg) r_prev_pc <= pc;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf      <= 1'b1;
      if (clr_ovf)          r_drop_cnt <= CNT_W'(1);
      else if (!(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end else if (clr_ovf) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SEND_PC;
        end
      end
      ST_SEND_PC: begin
        if (out_ready) w_state_nxt = ST_SEND_INST;
      end
      ST_SEND_INST: begin
        if (out_ready) begin
          if (!w_empty) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SEND_PC;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)    r_hold <= '0;
    else if (w_load) r_hold <= w_head;
  end

  // In IDLE the last word sent was an inst word, so showing r_hold.inst holds out_data.
  assign out_valid = (r_state != ST_IDLE);
  assign out_data  = (r_state == ST_SEND_PC) ? r_hold.pc : r_hold.inst;
  assign out_last  = (r_state == ST_SEND_INST);
  assign ovf_flag  = r_ovf;
  assign drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_pc_trace_buffer.sv
// Bench for pc_trace_buffer: vector table for capture/gating, scoreboard for the word stream,
// hand-written sequences for latency, backpressure, overflow and reset mid-stream.
module tb_pc_trace_buffer;
  localparam int          DEPTH = 4;
  localparam int          CNT_W = 16;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic                   clk_in = 1'b0;
  logic                   reset_n;
  logic                   trace_en;
  logic [31:0]            pc;
  logic [31:0]            inst;
  logic                   clr_ovf;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_data;
  logic                   out_last;
  logic                   ovf_flag;
  logic [CNT_W-1:0]       drop_cnt;
  logic [$clog2(DEPTH):0] level;

  pc_trace_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .trace_en(trace_en), .pc(pc), .inst(inst),
    .clr_ovf(clr_ovf), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .ovf_flag(ovf_flag), .drop_cnt(drop_cnt), .level(level)
  );

  always #5 clk_in = ~clk_in;

  typedef struct { logic en; logic [31:0] pc; logic [31:0] inst; bit logged; } vec_t;
  typedef struct { logic [31:0] data; logic last; } word_t;

  word_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void expect_ev(input logic [31:0] p, input logic [31:0] i);
    exp_q.push_back('{data: p, last: 1'b0});
    exp_q.push_back('{data: i, last: 1'b1});
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_pc(input logic [31:0] p, input bit logged);
    pc   = p;
    inst = $urandom;
    if (logged) expect_ev(p, inst);
  endtask

  // Scoreboard: a handshake seen at the negedge completes on the following posedge.
  always @(negedge clk_in) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %0h last=%0b, expected no word", out_data, out_last);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        chk("word_data", {32'h0, out_data}, {32'h0, w.data});
        chk("word_last", {63'h0, out_last}, {63'h0, w.last});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end of test");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 32'h0040_0008, 32'h1111_0000, 1'b0};
    vecs[1] = '{1'b1, 32'h0040_0008, 32'h2222_0000, 1'b0};
    vecs[2] = '{1'b1, 32'h0040_000c, 32'h3333_0000, 1'b1};
    vecs[3] = '{1'b1, 32'h0040_000c, 32'h4444_0000, 1'b0};
    vecs[4] = '{1'b1, 32'h0040_0000, 32'h5555_0000, 1'b1};
    vecs[5] = '{1'b0, 32'h0040_0010, 32'h6666_0000, 1'b0};
    vecs[6] = '{1'b1, 32'h0040_0020, 32'h7777_0000, 1'b1};
    vecs[7] = '{1'b1, 32'hffff_fffc, 32'h8888_0000, 1'b1};

    // Boot
    reset_n = 1'b0; trace_en = 1'b1; pc = RPC; inst = 32'h0; clr_ovf = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_data", {32'h0, out_data}, 64'h0);
    chk("rst_last", {63'h0, out_last}, 64'h0);
    chk("rst_ovf", {63'h0, ovf_flag}, 64'h0);
    chk("rst_drop", {48'h0, drop_cnt}, 64'h0);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk_in);
      chk("boot_valid", {63'h0, out_valid}, 64'h0);
      chk("boot_level", {61'h0, level}, 64'h0);
    end

    // Single event latency
    step();
    pc = 32'h0040_0004; inst = 32'h3c01_0040; expect_ev(pc, inst);
    @(negedge clk_in); chk("lat_e0_valid", {63'h0, out_valid}, 64'h0);
    @(negedge clk_in); chk("lat_e1_valid", {63'h0, out_valid}, 64'h0);
    chk("lat_e1_level", {61'h0, level}, 64'h1);
    @(negedge clk_in); chk("lat_e2_valid", {63'h0, out_valid}, 64'h1);
    chk("lat_e2_level", {61'h0, level}, 64'h0);
    repeat (3) @(negedge clk_in);
    chk("lat_idle", {63'h0, out_valid}, 64'h0);

    // Table: capture and trace_en gating with free-flowing output
    for (int k = 0; k < 8; k++) begin
      step();
      trace_en = vecs[k].en; pc = vecs[k].pc; inst = vecs[k].inst;
      if (vecs[k].logged) expect_ev(vecs[k].pc, vecs[k].inst);
      repeat (6) @(negedge clk_in);
      chk("tbl_level", {61'h0, level}, 64'h0);
      chk("tbl_valid", {63'h0, out_valid}, 64'h0);
      chk("tbl_queue", 64'(exp_q.size()), 64'h0);
    end
    trace_en = 1'b1;

    // Backpressure: three events, then a contiguous 6-word burst
    step(); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      drive_pc(32'h0000_1000 + 32'(k * 4), 1'b1);
    end
    step();
    @(negedge clk_in);
    chk("bp_level", {61'h0, level}, 64'h2);
    chk("bp_valid", {63'h0, out_valid}, 64'h1);
    chk("bp_hold_pc", {32'h0, out_data}, 64'h1000);
    step(); out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      chk("bp_burst_valid", {63'h0, out_valid}, 64'h1);
    end
    @(negedge clk_in);
    chk("bp_done_valid", {63'h0, out_valid}, 64'h0);
    chk("bp_done_level", {61'h0, level}, 64'h0);

    // Overflow: 1 held + 4 buffered, 2 dropped
    step(); out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) step();
      drive_pc(32'h0000_2000 + 32'(k * 4), k < 5);
    end
    step();
    @(negedge clk_in);
    chk("ovf_level", {61'h0, level}, 64'h4);
    chk("ovf_drop", {48'h0, drop_cnt}, 64'h2);
    chk("ovf_flag", {63'h0, ovf_flag}, 64'h1);
    chk("ovf_hold_pc", {32'h0, out_data}, 64'h2000);
    step(); clr_ovf = 1'b1;
    step(); clr_ovf = 1'b0;
    @(negedge clk_in);
    chk("clr_flag", {63'h0, ovf_flag}, 64'h0);
    chk("clr_drop", {48'h0, drop_cnt}, 64'h0);
    // clear and drop in the same cycle: drop wins
    step(); clr_ovf = 1'b1; drive_pc(32'h0000_3000, 1'b0);
    step(); clr_ovf = 1'b0;
    @(negedge clk_in);
    chk("clrdrop_flag", {63'h0, ovf_flag}, 64'h1);
    chk("clrdrop_drop", {48'h0, drop_cnt}, 64'h1);
    step(); clr_ovf = 1'b1;
    step(); clr_ovf = 1'b0;
    // full FIFO with a pop in the same cycle still drops
    step(); out_ready = 1'b1;
    step(); drive_pc(32'h0000_3004, 1'b0);
    step(); out_ready = 1'b0;
    @(negedge clk_in);
    chk("popdrop_drop", {48'h0, drop_cnt}, 64'h1);
    chk("popdrop_level", {61'h0, level}, 64'h3);
    step(); clr_ovf = 1'b1; out_ready = 1'b1;
    step(); clr_ovf = 1'b0;
    repeat (20) @(negedge clk_in);
    chk("ovf_drain_queue", 64'(exp_q.size()), 64'h0);
    chk("ovf_drain_level", {61'h0, level}, 64'h0);

    // Reset during SEND_INST
    step(); out_ready = 1'b0; drive_pc(32'h0000_4000, 1'b1);
    repeat (3) step();
    out_ready = 1'b1;
    step(); out_ready = 1'b0;
    @(negedge clk_in);
    chk("mid_valid", {63'h0, out_valid}, 64'h1);
    chk("mid_last", {63'h0, out_last}, 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'h0, out_valid}, 64'h0);
    chk("mid_rst_level", {61'h0, level}, 64'h0);
    exp_q.delete();
    pc = RPC;
    step(); reset_n = 1'b1; out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk_in);
      chk("post_rst_valid", {63'h0, out_valid}, 64'h0);
    end
    chk("post_rst_level", {61'h0, level}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
